// File: rtl/mem_port_arbiter_if.sv
// Handshake bundle between the two requesters (F, D), the arbiter and the RAM port.
interface mem_port_arbiter_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 8
);
  logic                     f_req, d_req, f_lock, d_lock, f_we, d_we;
  logic [ADDRESS_WIDTH-1:0] f_addr, d_addr;
  logic [DATA_WIDTH-1:0]    f_wdata, d_wdata, f_rdata, d_rdata;
  logic                     f_busy, d_busy, f_done, d_done, f_err, d_err;
  logic [ADDRESS_WIDTH-1:0] mem_addr;
  logic                     mem_we, mem_req, mem_busy;
  logic [DATA_WIDTH-1:0]    mem_wdata, mem_rdata;

  // arbiter side
  modport slave (
    input  f_req, d_req, f_lock, d_lock, f_we, d_we, f_addr, d_addr, f_wdata, d_wdata,
           mem_rdata, mem_busy,
    output f_rdata, d_rdata, f_busy, d_busy, f_done, d_done, f_err, d_err,
           mem_addr, mem_we, mem_wdata, mem_req
  );

  // requesters + RAM side
  modport master (
    output f_req, d_req, f_lock, d_lock, f_we, d_we, f_addr, d_addr, f_wdata, d_wdata,
           mem_rdata, mem_busy,
    input  f_rdata, d_rdata, f_busy, d_busy, f_done, d_done, f_err, d_err,
           mem_addr, mem_we, mem_wdata, mem_req
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for one byte-wide RAM port with locked bursts and busy watchdog.
// Optional MEM_ARB_ROUND_ROBIN_EN: round-robin on simultaneous requests instead of D-first.
module mem_port_arbiter #(
  parameter int ADDRESS_WIDTH  = 32,
  parameter int DATA_WIDTH     = 8,
  parameter int LOCK_MAX       = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  mem_port_arbiter_if.slave    bus
);
  localparam int LOCK_W = $clog2(LOCK_MAX + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t                   state;
  logic                     ownD;
  logic [LOCK_W-1:0]        lockCnt;
  logic [7:0]               timer;
  logic                     winD, selD, ownLock, ownReq, lockOk;
  logic [ADDRESS_WIDTH-1:0] selAddr;
  logic                     selWe;
  logic [DATA_WIDTH-1:0]    selWdata;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic lastD;
  always_comb begin
    winD = bus.d_req & (~bus.f_req | ~lastD);
  end
`else
  always_comb begin
    winD = bus.d_req;
  end
`endif

  // IDLE latches the arbitration winner; DONE re-latches the current owner for a locked beat
  assign selD     = (state == IDLE) ? winD : ownD;
  assign selAddr  = selD ? bus.d_addr  : bus.f_addr;
  assign selWe    = selD ? bus.d_we    : bus.f_we;
  assign selWdata = selD ? bus.d_wdata : bus.f_wdata;
  assign ownLock  = ownD ? bus.d_lock  : bus.f_lock;
  assign ownReq   = ownD ? bus.d_req   : bus.f_req;
  assign lockOk   = ownLock & ownReq & ~(bus.f_err | bus.d_err) &
                    (32'(lockCnt) + 1 < LOCK_MAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      ownD          <= 1'b0;
      lockCnt       <= '0;
      timer         <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      lastD         <= 1'b1;
`endif
      bus.mem_addr  <= '0;
      bus.mem_we    <= 1'b0;
      bus.mem_wdata <= '0;
      bus.mem_req   <= 1'b0;
      bus.f_rdata   <= '0;
      bus.d_rdata   <= '0;
      bus.f_busy    <= 1'b0;
      bus.d_busy    <= 1'b0;
      bus.f_done    <= 1'b0;
      bus.d_done    <= 1'b0;
      bus.f_err     <= 1'b0;
      bus.d_err     <= 1'b0;
    end else begin
      bus.mem_req <= 1'b0;
      bus.f_done  <= 1'b0;
      bus.d_done  <= 1'b0;
      bus.f_err   <= 1'b0;
      bus.d_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.f_req | bus.d_req) begin
            ownD          <= winD;
            bus.mem_addr  <= selAddr;
            bus.mem_we    <= selWe;
            bus.mem_wdata <= selWdata;
            bus.f_busy    <= ~winD;
            bus.d_busy    <= winD;
            bus.mem_req   <= 1'b1;
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          timer <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (!bus.mem_busy) begin
            if (!bus.mem_we) begin
              if (ownD) bus.d_rdata <= bus.mem_rdata;
              else      bus.f_rdata <= bus.mem_rdata;
            end
            bus.f_done <= ~ownD;
            bus.d_done <= ownD;
            bus.f_busy <= 1'b0;
            bus.d_busy <= 1'b0;
            state      <= DONE;
          end else if (timer == 8'(TIMEOUT_CYCLES - 1)) begin
            bus.f_err  <= ~ownD;
            bus.d_err  <= ownD;
            bus.f_busy <= 1'b0;
            bus.d_busy <= 1'b0;
            state      <= DONE;
          end else begin
            timer <= timer + 8'd1;
          end
        end
        DONE: begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
          lastD <= ownD;
`endif
          if (lockOk) begin
            lockCnt       <= lockCnt + LOCK_W'(1);
            bus.mem_addr  <= selAddr;
            bus.mem_we    <= selWe;
            bus.mem_wdata <= selWdata;
            bus.f_busy    <= ~ownD;
            bus.d_busy    <= ownD;
            bus.mem_req   <= 1'b1;
            state         <= ISSUE;
          end else begin
            lockCnt <= '0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: vector table plus lock, timeout, reset and fairness sequences.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
  mem_port_arbiter #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .LOCK_MAX(4), .TIMEOUT_CYCLES(255))
    dut (.clk(clk), .reset(reset), .bus(bus));

`ifdef MEM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct {
    bit          fReq, dReq;
    logic [31:0] fAddr, dAddr;
    bit          fWe, dWe;
    logic [7:0]  fWd, dWd;
    int          busyN;
    logic [7:0]  rd;
    bit          expD;
    logic [7:0]  expFR, expDR;
  } vec_t;

  vec_t vt[6];
  int nChk = 0;
  int nFail = 0;

  logic [31:0] gAddr;
  logic [7:0]  gWd;
  logic        gWe, gFBusy, gDBusy, gReq2, gPulse2, gNextReq;
  logic [3:0]  gPulse;
  int          gLat;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChk++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] pulses();
    return {bus.f_done, bus.d_done, bus.f_err, bus.d_err};
  endfunction

  task automatic waitIssue();
    int n = 0;
    while (!bus.mem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("issue_seen", 32'(bus.mem_req), 32'd1);
    gAddr  = bus.mem_addr;
    gWe    = bus.mem_we;
    gWd    = bus.mem_wdata;
    gFBusy = bus.f_busy;
    gDBusy = bus.d_busy;
  endtask

  task automatic finishTxn(input int busyN, input logic [7:0] rd, input bit stuck);
    int n = 0;
    bus.mem_busy = 1'b1;
    @(negedge clk);
    gReq2 = bus.mem_req;
    gLat  = 1;
    if (!stuck) begin
      repeat (busyN - 1) begin
        @(negedge clk);
        gLat++;
      end
      bus.mem_busy  = 1'b0;
      bus.mem_rdata = rd;
    end
    while (pulses() == 4'b0 && n < 400) begin
      @(negedge clk);
      gLat++;
      n++;
    end
    gPulse = pulses();
    bus.mem_busy = 1'b0;
    @(negedge clk);
    gPulse2  = |pulses();
    gNextReq = bus.mem_req;
  endtask

  task automatic expectTxn(input string tag, input bit expD, input logic [31:0] addr,
                           input bit we, input logic [7:0] wd, input int lat, input bit expErr);
    chk({tag, "_busy"}, 32'({gFBusy, gDBusy}), expD ? 32'd1 : 32'd2);
    chk({tag, "_addr"}, gAddr, addr);
    chk({tag, "_we"}, 32'(gWe), 32'(we));
    chk({tag, "_wdata"}, 32'(gWd), 32'(wd));
    chk({tag, "_req_once"}, 32'(gReq2), 32'd0);
    chk({tag, "_latency"}, 32'(gLat), 32'(lat));
    chk({tag, "_pulse"}, 32'(gPulse),
        expErr ? (expD ? 32'h1 : 32'h2) : (expD ? 32'h4 : 32'h8));
    chk({tag, "_pulse_len"}, 32'(gPulse2), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //       fReq dReq fAddr          dAddr     fWe dWe fWd    dWd    busy rd     expD fR     dR
    vt[0] = '{1, 0, 32'h10,        32'h0,  0, 0, 8'h00, 8'h00, 2, 8'hA5, 0, 8'hA5, 8'h00};
    vt[1] = '{0, 1, 32'h0,         32'h44, 0, 0, 8'h00, 8'h00, 1, 8'h5A, 1, 8'hA5, 8'h5A};
    vt[2] = '{1, 0, 32'h33,        32'h0,  1, 0, 8'h77, 8'h00, 3, 8'hEE, 0, 8'hA5, 8'h5A};
    vt[3] = '{1, 1, 32'h30,        32'h20, 0, 1, 8'h00, 8'h3C, 2, 8'h99, 1, 8'hA5, 8'h5A};
    vt[4] = '{0, 1, 32'h0,         32'h08, 0, 0, 8'h00, 8'h00, 1, 8'h11, 1, 8'hA5, 8'h11};
    vt[5] = '{1, 0, 32'hFFFFFFFF,  32'h0,  0, 0, 8'h00, 8'h00, 4, 8'hFF, 0, 8'hFF, 8'h11};

    bus.f_req = 0; bus.d_req = 0; bus.f_lock = 0; bus.d_lock = 0;
    bus.f_we = 0; bus.d_we = 0; bus.f_addr = '0; bus.d_addr = '0;
    bus.f_wdata = '0; bus.d_wdata = '0; bus.mem_rdata = '0; bus.mem_busy = 0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ctrl", 32'({bus.mem_req, bus.mem_we, bus.f_busy, bus.d_busy, pulses()}), 32'd0);
    chk("rst_rdata", 32'({bus.f_rdata, bus.d_rdata}), 32'd0);
    chk("rst_addr", bus.mem_addr, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      bus.f_req = vt[i].fReq;  bus.d_req = vt[i].dReq;
      bus.f_addr = vt[i].fAddr; bus.d_addr = vt[i].dAddr;
      bus.f_we = vt[i].fWe;    bus.d_we = vt[i].dWe;
      bus.f_wdata = vt[i].fWd; bus.d_wdata = vt[i].dWd;
      waitIssue();
      bus.f_req = 0; bus.d_req = 0;
      finishTxn(vt[i].busyN, vt[i].rd, 0);
      expectTxn($sformatf("vec%0d", i), vt[i].expD,
                vt[i].expD ? vt[i].dAddr : vt[i].fAddr,
                vt[i].expD ? vt[i].dWe : vt[i].fWe,
                vt[i].expD ? vt[i].dWd : vt[i].fWd, vt[i].busyN + 1, 0);
      chk($sformatf("vec%0d_f_rdata", i), 32'(bus.f_rdata), 32'(vt[i].expFR));
      chk($sformatf("vec%0d_d_rdata", i), 32'(bus.d_rdata), 32'(vt[i].expDR));
    end

    // contention: D write first, pending F served without re-requesting
    bus.f_req = 1; bus.f_addr = 32'h50; bus.f_we = 0; bus.f_wdata = 8'h00;
    bus.d_req = 1; bus.d_addr = 32'h20; bus.d_we = 1; bus.d_wdata = 8'h3C;
    waitIssue();
    bus.d_req = 0;
    finishTxn(2, 8'h77, 0);
    expectTxn("cont_d", 1, 32'h20, 1, 8'h3C, 3, 0);
    chk("cont_d_rdata", 32'(bus.d_rdata), 32'h11);
    waitIssue();
    bus.f_req = 0;
    finishTxn(1, 8'h42, 0);
    expectTxn("cont_f", 0, 32'h50, 0, 8'h00, 2, 0);
    chk("cont_f_rdata", 32'(bus.f_rdata), 32'h42);

    // locked 4-beat fetch with D waiting; fifth locked beat refused
    bus.f_wdata = 0; bus.d_wdata = 0; bus.d_we = 0;
    bus.f_req = 1; bus.f_lock = 1; bus.f_addr = 32'h0;
    for (int b = 0; b < 4; b++) begin
      waitIssue();
      if (b == 0) begin
        bus.d_req = 1; bus.d_addr = 32'h60;
      end
      bus.f_addr = 32'(b + 1);
      finishTxn(1, 8'hB0 + 8'(b), 0);
      expectTxn($sformatf("lock%0d", b), 0, 32'(b), 0, 8'h00, 2, 0);
      chk($sformatf("lock%0d_rdata", b), 32'(bus.f_rdata), 32'(8'hB0 + 8'(b)));
      chk($sformatf("lock%0d_next_issue", b), 32'(gNextReq), (b < 3) ? 32'd1 : 32'd0);
    end
    waitIssue();
    bus.f_req = 0; bus.f_lock = 0; bus.d_req = 0;
    finishTxn(1, 8'hC3, 0);
    expectTxn("lock_after_d", 1, 32'h60, 0, 8'h00, 2, 0);
    chk("lock_after_d_rdata", 32'(bus.d_rdata), 32'hC3);

    // busy stuck high: err after 255 WAIT cycles, rdata untouched
    bus.f_req = 1; bus.f_addr = 32'h70;
    waitIssue();
    bus.f_req = 0;
    finishTxn(1, 8'h00, 1);
    expectTxn("tmo", 0, 32'h70, 0, 8'h00, 256, 1);
    chk("tmo_rdata", 32'(bus.f_rdata), 32'hB3);
    bus.d_req = 1; bus.d_addr = 32'h74;
    waitIssue();
    bus.d_req = 0;
    finishTxn(2, 8'h5D, 0);
    expectTxn("post_tmo", 1, 32'h74, 0, 8'h00, 3, 0);
    chk("post_tmo_rdata", 32'(bus.d_rdata), 32'h5D);

    // asynchronous reset in the middle of WAIT
    bus.f_req = 1; bus.f_addr = 32'h80;
    waitIssue();
    bus.f_req = 0;
    bus.mem_busy = 1;
    repeat (2) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    chk("rstw_ctrl", 32'({bus.mem_req, bus.mem_we, bus.f_busy, bus.d_busy, pulses()}), 32'd0);
    chk("rstw_data", 32'({bus.f_rdata, bus.d_rdata}), 32'd0);
    chk("rstw_addr", bus.mem_addr, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    bus.mem_busy = 0;
    begin
      logic [3:0] seen = 4'b0;
      repeat (4) begin
        @(negedge clk);
        seen = seen | pulses();
      end
      chk("rstw_no_pulse", 32'(seen), 32'd0);
    end
    bus.f_req = 1; bus.f_addr = 32'h84;
    bus.d_req = 1; bus.d_addr = 32'h88;
    waitIssue();
    bus.f_req = 0; bus.d_req = 0;
    finishTxn(1, 8'h66, 0);
    expectTxn("rstw_first", !RR, RR ? 32'h84 : 32'h88, 0, 8'h00, 2, 0);
    chk("rstw_first_rdata", 32'(RR ? bus.f_rdata : bus.d_rdata), 32'h66);

    // both requesting continuously: alternation under round robin, D always otherwise
    bus.f_req = 1; bus.f_addr = 32'h90;
    bus.d_req = 1; bus.d_addr = 32'h94;
    for (int k = 0; k < 4; k++) begin
      bit eD;
      eD = RR ? ((k % 2) == 0) : 1'b1;
      waitIssue();
      if (k == 3) begin
        bus.f_req = 0; bus.d_req = 0;
      end
      finishTxn(1, 8'h20 + 8'(k), 0);
      expectTxn($sformatf("fair%0d", k), eD, eD ? 32'h94 : 32'h90, 0, 8'h00, 2, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nChk, nFail);
    $finish;
  end
endmodule
